// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline definitions: control-field bit positions, bubble encoding
// and default datapath widths used by the ID/EX stage register.
package id_ex_stage_reg_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CTRL_W     = 8;

  // ctrl = {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, ALUOp[1:0]}
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 8'h00;

  // What the stage register does on the next clock edge.
  typedef enum logic [1:0] {
    UPD_CAPTURE = 2'd0,
    UPD_STALL   = 2'd1,
    UPD_FLUSH   = 2'd2
  } upd_e;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detector.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load currently in EX is about to write. Pure combinational.
module load_use_detector
  import id_ex_stage_reg_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              valid_idex,
  input  logic              memread_idex,
  input  logic [REG_AW-1:0] rd_idex,
  input  logic              valid_id,
  input  logic              use_rs1_id,
  input  logic              use_rs2_id,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              flush,
  output logic              lu,
  output logic              stall
);

  logic src_match;

  always_comb begin
    src_match = (use_rs1_id && (rd_idex == rs1_id)) ||
                (use_rs2_id && (rd_idex == rs2_id));
    lu        = valid_idex && memread_idex && (rd_idex != '0) && src_match && valid_id;
    // A taken branch discards the ID instruction, so there is nothing to stall for.
    stall     = lu && !flush;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch squash,
// same-cycle WB bypass into captured operands and a saturating bubble counter.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_ID,
  input  logic [XLEN-1:0]   rs1_data_ID,
  input  logic [XLEN-1:0]   rs2_data_ID,
  input  logic [XLEN-1:0]   imm_ID,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic [REG_AW-1:0] rd_ID,
  input  logic              use_rs1_ID,
  input  logic              use_rs2_ID,
  input  logic [CTRL_W-1:0] ctrl_ID,
  input  logic              valid_ID,
  input  logic              flush,
  input  logic              RegWrite_MEMWB,
  input  logic [REG_AW-1:0] rd_MEMWB,
  input  logic [XLEN-1:0]   wdata_MEMWB,
  output logic [XLEN-1:0]   pc_IDEX,
  output logic [XLEN-1:0]   rs1_data_IDEX,
  output logic [XLEN-1:0]   rs2_data_IDEX,
  output logic [XLEN-1:0]   imm_IDEX,
  output logic [REG_AW-1:0] rs1_IDEX,
  output logic [REG_AW-1:0] rs2_IDEX,
  output logic [REG_AW-1:0] rd_IDEX,
  output logic [CTRL_W-1:0] ctrl_IDEX,
  output logic              valid_IDEX,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Handshake: valid_IDEX=1 means EX holds a real instruction this cycle; there
  // is no ready back-pressure, a stall is signalled upstream via PCWrite/IFIDWrite=0.

  logic            lu;
  logic            stall;
  upd_e            upd;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  load_use_detector #(.REG_AW(REG_AW)) u_lud (
    .valid_idex   (valid_IDEX),
    .memread_idex (ctrl_IDEX[CTRL_MEMREAD]),
    .rd_idex      (rd_IDEX),
    .valid_id     (valid_ID),
    .use_rs1_id   (use_rs1_ID),
    .use_rs2_id   (use_rs2_ID),
    .rs1_id       (rs1_ID),
    .rs2_id       (rs2_ID),
    .flush        (flush),
    .lu           (lu),
    .stall        (stall)
  );

  always_comb begin
    PCWrite   = !stall;
    IFIDWrite = !stall;

    upd = UPD_CAPTURE;
    if (flush)   upd = UPD_FLUSH;
    else if (lu) upd = UPD_STALL;

    // The register file is read before WB writes it, so pick up the WB value here.
    rs1_fwd = rs1_data_ID;
    rs2_fwd = rs2_data_ID;
    if (RegWrite_MEMWB && (rd_MEMWB != '0) && (rd_MEMWB == rs1_ID)) rs1_fwd = wdata_MEMWB;
    if (RegWrite_MEMWB && (rd_MEMWB != '0) && (rd_MEMWB == rs2_ID)) rs2_fwd = wdata_MEMWB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_IDEX       <= '0;
      rs1_data_IDEX <= '0;
      rs2_data_IDEX <= '0;
      imm_IDEX      <= '0;
      rs1_IDEX      <= '0;
      rs2_IDEX      <= '0;
      rd_IDEX       <= '0;
      ctrl_IDEX     <= CTRL_BUBBLE;
      valid_IDEX    <= 1'b0;
      bubble_cnt    <= '0;
    end else begin
      case (upd)
        UPD_CAPTURE: begin
          pc_IDEX       <= pc_ID;
          rs1_data_IDEX <= rs1_fwd;
          rs2_data_IDEX <= rs2_fwd;
          imm_IDEX      <= imm_ID;
          rs1_IDEX      <= rs1_ID;
          rs2_IDEX      <= rs2_ID;
          rd_IDEX       <= rd_ID;
          ctrl_IDEX     <= valid_ID ? ctrl_ID : CTRL_BUBBLE;
          valid_IDEX    <= valid_ID;
        end
        default: begin
          pc_IDEX       <= '0;
          rs1_data_IDEX <= '0;
          rs2_data_IDEX <= '0;
          imm_IDEX      <= '0;
          rs1_IDEX      <= '0;
          rs2_IDEX      <= '0;
          rd_IDEX       <= '0;
          ctrl_IDEX     <= CTRL_BUBBLE;
          valid_IDEX    <= 1'b0;
          if ((upd == UPD_STALL) && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed hazard/flush/bypass/reset cases plus
// random traffic, checked against an instruction-level reference model.
module tb_id_ex_stage_reg;

  localparam int BW = 32 * 4 + 5 * 3 + 8 + 1 + 32 + 2;

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [7:0]  ctrl;
    logic        v, fl, wbwe;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
  } stim_t;

  logic        clk, rst;
  logic [31:0] pc_ID, rs1_data_ID, rs2_data_ID, imm_ID;
  logic [4:0]  rs1_ID, rs2_ID, rd_ID;
  logic        use_rs1_ID, use_rs2_ID;
  logic [7:0]  ctrl_ID;
  logic        valid_ID, flush, RegWrite_MEMWB;
  logic [4:0]  rd_MEMWB;
  logic [31:0] wdata_MEMWB;
  logic [31:0] pc_IDEX, rs1_data_IDEX, rs2_data_IDEX, imm_IDEX;
  logic [4:0]  rs1_IDEX, rs2_IDEX, rd_IDEX;
  logic [7:0]  ctrl_IDEX;
  logic        valid_IDEX, PCWrite, IFIDWrite;
  logic [31:0] bubble_cnt;
  logic [31:0] s_pc, s_rs1d, s_rs2d, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [7:0]  s_ctrl;
  logic        s_valid, s_pcw, s_ifw;
  logic [1:0]  s_cnt;

  logic [BW-1:0] exp_q[$];
  int n_checks, n_err;

  // reference model: the instruction that currently sits in EX
  logic       m_valid, m_memread;
  logic [4:0] m_rd;
  int         m_stalls;

  localparam logic [7:0] LW  = 8'hD8;  // RegWrite|MemRead|MemToReg|ALUSrc
  localparam logic [7:0] ADD = 8'h82;  // RegWrite, ALUOp=10

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .pc_ID(pc_ID), .rs1_data_ID(rs1_data_ID), .rs2_data_ID(rs2_data_ID),
    .imm_ID(imm_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID), .use_rs1_ID(use_rs1_ID),
    .use_rs2_ID(use_rs2_ID), .ctrl_ID(ctrl_ID), .valid_ID(valid_ID), .flush(flush),
    .RegWrite_MEMWB(RegWrite_MEMWB), .rd_MEMWB(rd_MEMWB), .wdata_MEMWB(wdata_MEMWB),
    .pc_IDEX(pc_IDEX), .rs1_data_IDEX(rs1_data_IDEX), .rs2_data_IDEX(rs2_data_IDEX),
    .imm_IDEX(imm_IDEX), .rs1_IDEX(rs1_IDEX), .rs2_IDEX(rs2_IDEX), .rd_IDEX(rd_IDEX),
    .ctrl_IDEX(ctrl_IDEX), .valid_IDEX(valid_IDEX), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance driven identically, for saturation.
  id_ex_stage_reg #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .pc_ID(pc_ID), .rs1_data_ID(rs1_data_ID), .rs2_data_ID(rs2_data_ID),
    .imm_ID(imm_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID), .use_rs1_ID(use_rs1_ID),
    .use_rs2_ID(use_rs2_ID), .ctrl_ID(ctrl_ID), .valid_ID(valid_ID), .flush(flush),
    .RegWrite_MEMWB(RegWrite_MEMWB), .rd_MEMWB(rd_MEMWB), .wdata_MEMWB(wdata_MEMWB),
    .pc_IDEX(s_pc), .rs1_data_IDEX(s_rs1d), .rs2_data_IDEX(s_rs2d),
    .imm_IDEX(s_imm), .rs1_IDEX(s_rs1), .rs2_IDEX(s_rs2), .rd_IDEX(s_rd),
    .ctrl_IDEX(s_ctrl), .valid_IDEX(s_valid), .PCWrite(s_pcw), .IFIDWrite(s_ifw),
    .bubble_cnt(s_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] dut_bundle();
    return {pc_IDEX, rs1_data_IDEX, rs2_data_IDEX, imm_IDEX, rs1_IDEX, rs2_IDEX, rd_IDEX,
            ctrl_IDEX, valid_IDEX, bubble_cnt, s_cnt};
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic stim_t instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                  input logic u1, input logic u2, input logic [7:0] ctrl);
    stim_t s;
    s.pc = $urandom; s.rs1d = $urandom; s.rs2d = $urandom; s.imm = $urandom;
    s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.u1 = u1; s.u2 = u2; s.ctrl = ctrl;
    s.v = 1'b1; s.fl = 1'b0; s.wbwe = 1'b0; s.wbrd = '0; s.wbd = '0;
    return s;
  endfunction

  // driver: one ID cycle; checks the stall outputs and predicts the EX contents
  task automatic issue(input stim_t s);
    logic        hz, st;
    logic [31:0] e_rs1d, e_rs2d;
    logic [BW-1:0] e;
    int          sat;
    @(negedge clk);
    pc_ID = s.pc; rs1_data_ID = s.rs1d; rs2_data_ID = s.rs2d; imm_ID = s.imm;
    rs1_ID = s.rs1; rs2_ID = s.rs2; rd_ID = s.rd; use_rs1_ID = s.u1; use_rs2_ID = s.u2;
    ctrl_ID = s.ctrl; valid_ID = s.v; flush = s.fl;
    RegWrite_MEMWB = s.wbwe; rd_MEMWB = s.wbrd; wdata_MEMWB = s.wbd;
    #1;
    hz = m_valid && m_memread && (m_rd != 0) && s.v &&
         ((s.u1 && m_rd == s.rs1) || (s.u2 && m_rd == s.rs2));
    st = hz && !s.fl;
    chk("pcwrite", BW'(PCWrite), BW'(!st));
    chk("ifidwrite", BW'(IFIDWrite), BW'(!st));
    if (s.fl || st) begin
      if (st) m_stalls++;
      sat = (m_stalls > 3) ? 3 : m_stalls;
      e = {128'd0, 15'd0, 8'd0, 1'b0, 32'(m_stalls), 2'(sat)};
      m_valid = 1'b0; m_memread = 1'b0; m_rd = '0;
    end else begin
      e_rs1d = (s.wbwe && s.wbrd != 0 && s.wbrd == s.rs1) ? s.wbd : s.rs1d;
      e_rs2d = (s.wbwe && s.wbrd != 0 && s.wbrd == s.rs2) ? s.wbd : s.rs2d;
      sat = (m_stalls > 3) ? 3 : m_stalls;
      e = {s.pc, e_rs1d, e_rs2d, s.imm, s.rs1, s.rs2, s.rd, (s.v ? s.ctrl : 8'h00), s.v,
           32'(m_stalls), 2'(sat)};
      m_valid = s.v; m_memread = s.v && s.ctrl[6]; m_rd = s.rd;
    end
    exp_q.push_back(e);
  endtask

  // monitor: every edge presents a new EX slot; compare against the queue head
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) chk("idex_bundle", dut_bundle(), exp_q.pop_front());
  end

  task automatic model_reset();
    m_valid = 1'b0; m_memread = 1'b0; m_rd = '0; m_stalls = 0;
  endtask

  initial begin
    stim_t s;
    n_checks = 0; n_err = 0;
    model_reset();
    rst = 1'b1;
    pc_ID = '0; rs1_data_ID = '0; rs2_data_ID = '0; imm_ID = '0; rs1_ID = '0; rs2_ID = '0;
    rd_ID = '0; use_rs1_ID = 1'b0; use_rs2_ID = 1'b0; ctrl_ID = '0; valid_ID = 1'b0;
    flush = 1'b0; RegWrite_MEMWB = 1'b0; rd_MEMWB = '0; wdata_MEMWB = '0;
    #12;
    chk("reset_outputs", dut_bundle(), '0);
    chk("reset_pcwrite", BW'({PCWrite, IFIDWrite}), BW'(2'b11));
    @(negedge clk); rst = 1'b0;

    // load-use: one bubble, then the dependent add is captured
    issue(instr(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, LW));
    issue(instr(5'd5, 5'd3, 5'd8, 1'b1, 1'b1, ADD));
    s = instr(5'd5, 5'd3, 5'd8, 1'b1, 1'b1, ADD);
    issue(s); issue(s);

    // no false stall: rd=0, and an unused rs2 match
    issue(instr(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, LW));
    issue(instr(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, ADD));
    issue(instr(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, LW));
    issue(instr(5'd3, 5'd5, 5'd9, 1'b1, 1'b0, ADD));

    // flush beats stall
    issue(instr(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, LW));
    s = instr(5'd5, 5'd3, 5'd8, 1'b1, 1'b1, ADD); s.fl = 1'b1;
    issue(s);

    // WB bypass, and index 0 never bypassed
    s = instr(5'd1, 5'd7, 5'd4, 1'b1, 1'b1, ADD);
    s.rs2d = '0; s.wbwe = 1'b1; s.wbrd = 5'd7; s.wbd = 32'hDEADBEEF;
    issue(s);
    s = instr(5'd1, 5'd0, 5'd4, 1'b1, 1'b1, ADD);
    s.rs2d = '0; s.wbwe = 1'b1; s.wbrd = 5'd0; s.wbd = 32'hDEADBEEF;
    issue(s);

    // back-to-back dependent loads, then enough stalls to saturate the 2-bit counter
    issue(instr(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, LW));
    s = instr(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, LW); issue(s); issue(s);
    s = instr(5'd6, 5'd0, 5'd9, 1'b1, 1'b0, ADD); issue(s); issue(s);
    for (int i = 0; i < 5; i++) begin
      issue(instr(5'd1, 5'd2, 5'd10, 1'b1, 1'b0, LW));
      s = instr(5'd3, 5'd10, 5'd11, 1'b1, 1'b1, ADD); issue(s); issue(s);
    end

    // reset asserted mid-stall
    issue(instr(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, LW));
    s = instr(5'd5, 5'd3, 5'd8, 1'b1, 1'b1, ADD);
    issue(s);
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("midstall_reset_outputs", dut_bundle(), '0);
    chk("midstall_reset_pcwrite", BW'({PCWrite, IFIDWrite}), BW'(2'b11));
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    model_reset();
    issue(s);

    // random traffic over a small register window
    for (int i = 0; i < 400; i++) begin
      s = instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom), 1'($urandom), 8'($urandom));
      if ($urandom_range(0, 2) == 0) s.ctrl = LW;
      s.v    = ($urandom_range(0, 7) != 0);
      s.fl   = ($urandom_range(0, 7) == 0);
      s.wbwe = 1'($urandom);
      s.wbrd = 5'($urandom_range(0, 7));
      s.wbd  = $urandom;
      issue(s);
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", BW'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
